n_m_serializer: RTL and testbench
=================================

# n_m_serializer

Parallel-to-serial converter for the SD host DAT path, the transmit-direction counterpart of the DAT deserializer. It accepts an n-bit word through a valid/ready handshake, buffers one word ahead, and drives it onto the m-bit DAT bus one m-bit slice per `sd_clock`, most-significant slice first. A one-word holding buffer lets consecutive words stream with no idle beat between them. It sits between the host write-data FIFO and the DAT line drivers.

## Interface
- `n`, 32, parallel word width; must be a multiple of `m`, with n/m >= 2
- `m`, 4, serial bus width (DAT lanes)
- `sd_clock` input 1: sole clock, rising-edge active
- `reset` input 1: asynchronous, active-low reset
- `parallel` input n: word to transmit
- `load` input 1: `parallel` is valid; a word is accepted on any rising edge where `load` && `ready`
- `enable` input 1: shift permission; when low, output beats freeze
- `serial` output m: current DAT slice
- `serial_valid` output 1: `serial` carries word data (DAT driver output enable)
- `ready` output 1: a word can be accepted (holding buffer empty)
- `complete` output 1: last slice of the current word is on `serial`

## Operation
- Storage:
  - shift register, n bits
  - holding register, n bits, with `hold_full` flag
  - beat counter, width clog2(n/m), range 0..n/m-1
- FSM:
  - IDLE: no word shifting
  - SHIFT: word in shift register
- `ready` = !`hold_full` (combinational from flag only; does not depend on `load`).
- IDLE:
  - When `load` is accepted, the word goes directly into the shift register.
  - Counter clears to 0 and the FSM moves to SHIFT.
  - `hold_full` stays 0.
- SHIFT:
  - `serial` = shift register slice [n-1-count*m -: m], so slice 0 is `parallel[n-1:n-m]`.
  - `serial_valid` = 1.
  - Non-last beat with `enable`=1: counter increments.
  - Any beat with `enable`=0: counter and shift register hold, and `serial` holds its value.
- Last beat (count = n/m-1) with `enable`=1; the next word source is chosen in this priority:
  - If `hold_full`: the holding register moves to the shift register, `hold_full` clears, counter goes to 0, and the FSM stays in SHIFT.
  - Else, if `load` is accepted this edge: the incoming word bypasses into the shift register, counter goes to 0, and the FSM stays in SHIFT.
  - Else: the FSM goes to IDLE.
- An accepted `load` in SHIFT that is not consumed by the bypass above writes the holding register and sets `hold_full`.
- A `load` while `ready`=0 is ignored. The holding register is never overwritten.
- `enable` has no effect on `load` acceptance.
- `complete` = (state==SHIFT) && (count==n/m-1). It stays high for as long as the last beat is held by `enable`=0.
- Counter arithmetic never wraps past n/m-1. Only the last-beat reload or IDLE entry returns it to 0.

## Timing
- Reset (asynchronous assert, release synchronous to `sd_clock`) sets:
  - FSM to IDLE, counter to 0, `hold_full` to 0
  - `serial` to idle value, `serial_valid` 0, `ready` 1, `complete` 0
- Reset asserted mid-word aborts the word immediately and discards the holding buffer.
- Latency: a word accepted at edge k in IDLE puts slice 0 on `serial` in the cycle after edge k.
- Throughput: one slice per `enable`-high cycle. n/m cycles per word, with zero gap when the next word is available by the last-beat edge.
- `serial` and `serial_valid` change only on rising edges (registered outputs). `ready` and `complete` are decoded from registered state.

## Configuration
- `N_M_SERIALIZER_IDLE_HIGH_EN`:
  - Defined: `serial` drives all ones when `serial_valid`=0 (SD DAT idle level).
  - Undefined: `serial` drives all zeros when `serial_valid`=0.
  - Data beats are identical in both builds.

## Test plan
- Single word: n=32, m=4, `enable`=1, load 0x12345678 in IDLE.
  - `serial` = 1,2,3,4,5,6,7,8 on 8 consecutive cycles.
  - `complete` high only with 8; then IDLE with idle value and `serial_valid`=0.
- Back-to-back: load 0x12345678, then load 0x9ABCDEF0 during beat 2.
  - `ready` falls after the second accept.
  - 16 contiguous slices 1..8,9,A..F,0 with no gap.
  - `ready` returns to 1 on the edge that reloads the shift register.
- Bypass on last beat: load the second word exactly while `complete`=1 with the holding buffer empty.
  - Slice 0 of the second word follows 8 with no gap.
  - `ready` stays 1.
- Stall: drop `enable` for 3 cycles while `serial`=4.
  - 4 held for 4 cycles total, then 5..8.
  - A `load` during the stall is accepted into the holding buffer.
- Overflow and reset: with the holding buffer full, assert `load` with 0xDEADBEEF.
  - The word is ignored and never appears on `serial`.
  - Then assert `reset` low mid-word: outputs take their reset values at once and stay there for the remaining cycles with no `load`.
- Idle level: run the single-word test with and without `N_M_SERIALIZER_IDLE_HIGH_EN`.
  - Idle `serial` = 4'hF and 4'h0 respectively.

Source files
------------

// File: rtl/n_m_serializer.sv
// SD host DAT transmit serializer: n-bit words out as m-bit slices, MSB slice first.
// Define N_M_SERIALIZER_IDLE_HIGH_EN to drive all ones on serial when idle (all zeros otherwise).
module n_m_serializer #(
    parameter int n = 32,
    parameter int m = 4
) (
    input  logic         sd_clock,
    input  logic         reset,
    input  logic [n-1:0] parallel,
    input  logic         load,
    input  logic         enable,
    output logic [m-1:0] serial,
    output logic         serial_valid,
    output logic         ready,
    output logic         complete
);
    localparam int BEATS = n / m;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

`ifdef N_M_SERIALIZER_IDLE_HIGH_EN
    localparam logic [m-1:0] IDLE_VAL = '1;
`else
    localparam logic [m-1:0] IDLE_VAL = '0;
`endif

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        state, state_next;
    logic [n-1:0]  shift_reg, hold_reg, shifted;
    logic          hold_full;
    logic [CW-1:0] count;
    logic          accept, at_last, reload;

    assign ready   = !hold_full;
    assign accept  = load && ready;
    assign at_last = (count == LAST);
    // Last-beat edge in SHIFT: the shift register takes the next word (hold or bypass).
    assign reload  = (state == SHIFT) && enable && at_last;

    always_ff @(posedge sd_clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (accept) state_next = SHIFT;
            SHIFT: if (reload && !hold_full && !accept) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sd_clock or negedge reset) begin
        if (!reset) begin
            shift_reg <= '0;
            hold_reg  <= '0;
            hold_full <= 1'b0;
            count     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        shift_reg <= parallel;
                        count     <= '0;
                    end
                end
                SHIFT: begin
                    if (enable) begin
                        if (!at_last) begin
                            count <= count + 1'b1;
                        end else begin
                            count <= '0;
                            if (hold_full) begin
                                shift_reg <= hold_reg;
                                hold_full <= 1'b0;
                            end else if (accept) begin
                                shift_reg <= parallel;
                            end
                        end
                    end
                    if (accept && !reload) begin
                        hold_reg  <= parallel;
                        hold_full <= 1'b1;
                    end
                end
                default: count <= '0;
            endcase
        end
    end

    assign shifted      = shift_reg << (32'(count) * m);
    assign serial_valid = (state == SHIFT);
    assign serial       = serial_valid ? shifted[n-1 -: m] : IDLE_VAL;
    assign complete     = (state == SHIFT) && at_last;
endmodule

// File: tb/tb_n_m_serializer.sv
// Self-checking bench for n_m_serializer: vector table, directed corner sequences, random vs. queue model.
module tb_n_m_serializer;
    logic        sd_clock = 1'b0;
    logic        reset    = 1'b0;
    logic [31:0] parallel = '0;
    logic        load     = 1'b0;
    logic        enable   = 1'b0;
    logic [3:0]  serial;
    logic        serial_valid, ready, complete;

`ifdef N_M_SERIALIZER_IDLE_HIGH_EN
    localparam logic [3:0] IDLE_V = 4'hF;
`else
    localparam logic [3:0] IDLE_V = 4'h0;
`endif

    int checks = 0;
    int passed = 0;

    n_m_serializer #(.n(32), .m(4)) dut (
        .sd_clock(sd_clock), .reset(reset), .parallel(parallel), .load(load),
        .enable(enable), .serial(serial), .serial_valid(serial_valid),
        .ready(ready), .complete(complete)
    );

    always #5 sd_clock = ~sd_clock;

    typedef struct {
        logic        load;
        logic        enable;
        logic [31:0] parallel;
        logic [3:0]  serial;
        logic        valid;
        logic        ready;
        logic        complete;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [3:0] s, input logic v,
                         input logic r, input logic c);
        checks++;
        if (serial === s && serial_valid === v && ready === r && complete === c)
            passed++;
        else
            $display("FAIL %s: got serial=%h valid=%b ready=%b complete=%b, want serial=%h valid=%b ready=%b complete=%b",
                     name, serial, serial_valid, ready, complete, s, v, r, c);
    endtask

    task automatic step(input logic l, input logic [31:0] p, input logic e);
        load = l; parallel = p; enable = e;
        @(posedge sd_clock); #1;
        load = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0; load = 1'b0; enable = 1'b0;
        @(posedge sd_clock); #1;
        reset = 1'b1;
    endtask

    // Expect the eight slices of word w starting at beat b0, with given ready level.
    task automatic expect_word(input string name, input logic [31:0] w, input int b0,
                               input logic r_level, input logic l, input logic [31:0] p);
        for (int b = b0; b < 8; b++) begin
            step((b == b0) ? l : 1'b0, p, 1'b1);
            check(name, 4'((w >> (28 - 4*b)) & 32'hF), 1'b1, r_level, b == 7);
        end
    endtask

    // Reference model: current word, beat position, queue of accepted-but-waiting words.
    logic [31:0] m_cur;
    int          m_beat;
    bit          m_active;
    logic [31:0] m_pend[$];

    task automatic model_clear();
        m_active = 0; m_beat = 0; m_pend.delete();
    endtask

    task automatic model_edge(input logic l, input logic [31:0] p, input logic e);
        bit acc;
        acc = l && (m_pend.size() == 0);
        if (!m_active) begin
            if (acc) begin m_cur = p; m_beat = 0; m_active = 1; end
        end else begin
            if (acc) m_pend.push_back(p);
            if (e) begin
                if (m_beat < 7) m_beat++;
                else if (m_pend.size() > 0) begin m_cur = m_pend.pop_front(); m_beat = 0; end
                else m_active = 0;
            end
        end
    endtask

    task automatic model_check(input string name);
        logic [3:0] s;
        s = m_active ? 4'((m_cur >> (28 - 4*m_beat)) & 32'hF) : IDLE_V;
        check(name, s, m_active, m_pend.size() == 0, m_active && m_beat == 7);
    endtask

    initial begin
        // Single word then bypass of a second word on its last beat, then idle.
        vecs[0] = '{1'b1, 1'b1, 32'h12345678, 4'h1, 1'b1, 1'b1, 1'b0};
        for (int i = 1; i < 8; i++)
            vecs[i] = '{1'b0, 1'b1, 32'h0, 4'(i + 1), 1'b1, 1'b1, i == 7};
        vecs[8] = '{1'b1, 1'b1, 32'h9ABCDEF0, 4'h9, 1'b1, 1'b1, 1'b0};
        for (int i = 9; i < 16; i++)
            vecs[i] = '{1'b0, 1'b1, 32'h0, 4'((32'h9ABCDEF0 >> (28 - 4*(i-8))) & 32'hF), 1'b1, 1'b1, i == 15};
        vecs[16] = '{1'b0, 1'b1, 32'h0, IDLE_V, 1'b0, 1'b1, 1'b0};

        #1;
        check("reset_async", IDLE_V, 1'b0, 1'b1, 1'b0);
        do_reset();
        check("reset_release", IDLE_V, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 17; i++) begin
            step(vecs[i].load, vecs[i].parallel, vecs[i].enable);
            check($sformatf("vec%0d", i), vecs[i].serial, vecs[i].valid, vecs[i].ready, vecs[i].complete);
        end

        // Back-to-back through the holding buffer.
        do_reset();
        step(1'b1, 32'h12345678, 1'b1); check("b2b_s1", 4'h1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1);        check("b2b_s2", 4'h2, 1'b1, 1'b1, 1'b0);
        step(1'b1, 32'h9ABCDEF0, 1'b1); check("b2b_s3", 4'h3, 1'b1, 1'b0, 1'b0);
        for (int b = 3; b < 8; b++) begin
            step(1'b0, 32'h0, 1'b1);
            check("b2b_hold", 4'(b + 1), 1'b1, 1'b0, b == 7);
        end
        expect_word("b2b_w2", 32'h9ABCDEF0, 0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b1); check("b2b_idle", IDLE_V, 1'b0, 1'b1, 1'b0);

        // Stall with a load landing in the holding buffer.
        do_reset();
        expect_word("stall_pre", 32'h12345678, 0, 1'b1, 1'b1, 32'h12345678);
        do_reset();
        step(1'b1, 32'h12345678, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1); check("stall_4", 4'h4, 1'b1, 1'b1, 1'b0);
        step(1'b1, 32'hCAFEF00D, 1'b0); check("stall_a", 4'h4, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0);        check("stall_b", 4'h4, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0);        check("stall_c", 4'h4, 1'b1, 1'b0, 1'b0);
        for (int b = 4; b < 8; b++) begin
            step(1'b0, 32'h0, 1'b1);
            check("stall_post", 4'(b + 1), 1'b1, 1'b0, b == 7);
        end
        // Last beat held by enable low keeps complete up.
        step(1'b0, 32'h0, 1'b0); check("stall_last", 4'h8, 1'b1, 1'b0, 1'b1);
        expect_word("stall_w2", 32'hCAFEF00D, 0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b1); check("stall_idle", IDLE_V, 1'b0, 1'b1, 1'b0);

        // Overflow: a load while the holding buffer is full is dropped.
        do_reset();
        step(1'b1, 32'h12345678, 1'b1); check("ovf_s1", 4'h1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 32'h9ABCDEF0, 1'b1); check("ovf_s2", 4'h2, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'hDEADBEEF, 1'b1); check("ovf_s3", 4'h3, 1'b1, 1'b0, 1'b0);
        for (int b = 3; b < 8; b++) begin
            step(1'b0, 32'h0, 1'b1);
            check("ovf_hold", 4'(b + 1), 1'b1, 1'b0, b == 7);
        end
        expect_word("ovf_w2", 32'h9ABCDEF0, 0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b1); check("ovf_idle", IDLE_V, 1'b0, 1'b1, 1'b0);

        // Reset mid-word with the holding buffer full.
        step(1'b1, 32'h12345678, 1'b1);
        step(1'b1, 32'h9ABCDEF0, 1'b1);
        step(1'b0, 32'h0, 1'b1); check("rst_pre", 4'h3, 1'b1, 1'b0, 1'b0);
        #2 reset = 1'b0; #1;
        check("rst_async", IDLE_V, 1'b0, 1'b1, 1'b0);
        @(posedge sd_clock); #1; check("rst_held", IDLE_V, 1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0, 1'b1);
            check("rst_after", IDLE_V, 1'b0, 1'b1, 1'b0);
        end

        // Randomized run against the queue model, with occasional resets.
        do_reset();
        model_clear();
        for (int i = 0; i < 3000; i++) begin
            logic        l, e;
            logic [31:0] p;
            if ($urandom_range(199) == 0) begin
                reset = 1'b0; #1;
                model_clear();
                model_check("rand_rst");
                @(posedge sd_clock); #1;
                reset = 1'b1;
                continue;
            end
            l = ($urandom_range(99) < 40);
            e = ($urandom_range(99) < 75);
            p = $urandom;
            model_edge(l, p, e);
            step(l, p, e);
            model_check("rand");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
